// File: rtl/ptmch_spi_mst.sv
// SPI mode-0 master (MSB first) issuing serial-NAND style frames:
// opcode, 0-3 address bytes, 0-2 write bytes, then 0-2 read bytes captured from MISO.
module ptmch_spi_mst #(
    parameter int P_CLKDIV   = 4,
    parameter int P_CS_SETUP = 4,
    parameter int P_CS_HOLD  = 4,
    parameter int P_CS_IDLE  = 8
) (
    input  logic        CLK160M,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [7:0]  CMD_OP,
    input  logic [1:0]  CMD_NADDR,
    input  logic [23:0] CMD_ADDR,
    input  logic [1:0]  CMD_NWR,
    input  logic [15:0] CMD_WDATA,
    input  logic [1:0]  CMD_NRD,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic        DONE,
    output logic        BUSY,
    output logic        SPI_CS,
    output logic        SPI_CLK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic [2:0]  DBG_STATE
);

    // Handshake: a command is accepted on a rising CLK160M edge where CMD_VALID and
    // CMD_READY are both high; CMD_READY is only high in IDLE and never depends on CMD_VALID.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] CLKDIV_M1 = 8'(P_CLKDIV - 1);
    localparam logic [7:0] SETUP_M1  = 8'(P_CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1   = 8'(P_CS_HOLD - 1);
    localparam logic [7:0] IDLE_M1   = 8'(P_CS_IDLE - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        half_q, half_d;
    logic [6:0]  bit_q, bit_d;
    logic [6:0]  last_bit_q, last_bit_d;
    logic [1:0]  nrd_q, nrd_d;
    logic [63:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic [1:0]  nwr_sat, nrd_sat;
    logic [3:0]  tx_bytes, all_bytes;
    logic [63:0] frame;

    // Transmit bytes packed MSB-first and left-justified; read-phase bits are the zero tail.
    always_comb begin
        nwr_sat   = (CMD_NWR == 2'd3) ? 2'd2 : CMD_NWR;
        nrd_sat   = (CMD_NRD == 2'd3) ? 2'd2 : CMD_NRD;
        tx_bytes  = 4'd1 + {2'b00, CMD_NADDR} + {2'b00, nwr_sat};
        all_bytes = tx_bytes + {2'b00, nrd_sat};
        frame     = {56'd0, CMD_OP};
        for (int i = 2; i >= 0; i--) begin
            if (i < int'(CMD_NADDR)) frame = {frame[55:0], CMD_ADDR[8*i +: 8]};
        end
        for (int i = 1; i >= 0; i--) begin
            if (i < int'(nwr_sat)) frame = {frame[55:0], CMD_WDATA[8*i +: 8]};
        end
        frame = frame << (7'd64 - {tx_bytes, 3'b000});
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        nrd_d      = nrd_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    state_d    = S_SETUP;
                    cnt_d      = 8'd0;
                    half_d     = 1'b0;
                    bit_d      = 7'd0;
                    last_bit_d = {all_bytes, 3'b000} - 7'd1;
                    nrd_d      = nrd_sat;
                    tx_d       = frame;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_M1) begin
                    state_d = S_SHIFT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != CLKDIV_M1) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!half_q) begin
                    cnt_d  = 8'd0;
                    half_d = 1'b1;
                end else begin
                    // End of the high half: sample MISO, advance MOSI for the next low half.
                    cnt_d  = 8'd0;
                    half_d = 1'b0;
                    rx_d   = {rx_q[14:0], SPI_MISO};
                    tx_d   = {tx_q[62:0], 1'b0};
                    if (bit_q == last_bit_q) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q + 7'd1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_M1) begin
                    state_d    = S_GAP;
                    cnt_d      = 8'd0;
                    done_d     = 1'b1;
                    rd_valid_d = (nrd_q != 2'd0);
                    if (nrd_q == 2'd1) rd_data_d = {8'h00, rx_q[7:0]};
                    else if (nrd_q == 2'd2) rd_data_d = rx_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == IDLE_M1) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK160M or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            half_q      <= 1'b0;
            bit_q       <= 7'd0;
            last_bit_q  <= 7'd0;
            nrd_q       <= 2'd0;
            tx_q        <= 64'd0;
            rx_q        <= 16'd0;
            rd_data_q   <= 16'd0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            bit_q       <= bit_d;
            last_bit_q  <= last_bit_d;
            nrd_q       <= nrd_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign RD_DATA   = rd_data_q;
    assign RD_VALID  = rd_valid_q;
    assign DONE      = done_q;
    assign BUSY      = (state_q != S_IDLE);
    assign SPI_CS    = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    assign SPI_CLK   = (state_q == S_SHIFT) && half_q;
    assign SPI_MOSI  = ((state_q == S_SETUP) || (state_q == S_SHIFT)) ? tx_q[63] : 1'b0;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ptmch_spi_mst.sv
// Directed bench for ptmch_spi_mst: one default instance and one with P_CLKDIV=1,
// each watched by a bus monitor that also plays the flash (drives MISO after SPI_CLK falls).
module tb_ptmch_spi_mst;
    localparam time CYC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic        cmd_valid0 = 1'b0;
    logic        cmd_valid1 = 1'b0;
    logic [7:0]  cmd_op     = 8'h00;
    logic [1:0]  cmd_naddr  = 2'd0;
    logic [23:0] cmd_addr   = 24'h0;
    logic [1:0]  cmd_nwr    = 2'd0;
    logic [15:0] cmd_wdata  = 16'h0;
    logic [1:0]  cmd_nrd    = 2'd0;

    logic        ready0, rvalid0, done0, busy0, cs0, sclk0, mosi0;
    logic        ready1, rvalid1, done1, busy1, cs1, sclk1, mosi1;
    logic [15:0] rdata0, rdata1;
    logic [2:0]  dbg0, dbg1;
    logic        miso0 = 1'b0;
    logic        miso1 = 1'b0;

    ptmch_spi_mst dut0 (
        .CLK160M(clk), .RESET(rst), .CMD_VALID(cmd_valid0), .CMD_READY(ready0),
        .CMD_OP(cmd_op), .CMD_NADDR(cmd_naddr), .CMD_ADDR(cmd_addr), .CMD_NWR(cmd_nwr),
        .CMD_WDATA(cmd_wdata), .CMD_NRD(cmd_nrd), .RD_DATA(rdata0), .RD_VALID(rvalid0),
        .DONE(done0), .BUSY(busy0), .SPI_CS(cs0), .SPI_CLK(sclk0), .SPI_MOSI(mosi0),
        .SPI_MISO(miso0), .DBG_STATE(dbg0)
    );

    ptmch_spi_mst #(.P_CLKDIV(1)) dut1 (
        .CLK160M(clk), .RESET(rst), .CMD_VALID(cmd_valid1), .CMD_READY(ready1),
        .CMD_OP(cmd_op), .CMD_NADDR(cmd_naddr), .CMD_ADDR(cmd_addr), .CMD_NWR(cmd_nwr),
        .CMD_WDATA(cmd_wdata), .CMD_NRD(cmd_nrd), .RD_DATA(rdata1), .RD_VALID(rvalid1),
        .DONE(done1), .BUSY(busy1), .SPI_CS(cs1), .SPI_CLK(sclk1), .SPI_MOSI(mosi1),
        .SPI_MISO(miso1), .DBG_STATE(dbg1)
    );

    // Flash model settings written by the tests: read word (left-justified) and command bit count.
    logic [15:0] miso_word0 = 16'h0;
    logic [15:0] miso_word1 = 16'h0;
    int          miso_bits0 = 64;
    int          miso_bits1 = 64;

    // Monitor for dut0
    logic        pclk0 = 1'b0, pcs0 = 1'b1;
    int          n_rise0 = 0, n_frise0 = 0, n_cslow0 = 0, n_done0 = 0, n_rv0 = 0;
    int          n_bper0 = 0, n_bduty0 = 0, n_rdybusy0 = 0, n_csfall0 = 0, hi_len0 = 0;
    time         t_rise0 = 0, t_done0 = 0, t_rv0 = 0, t_csrise0 = 0, t_csfall0 = 0;
    logic [63:0] mosi_log0 = 64'h0;
    logic [15:0] miso_sr0 = 16'h0;

    always @(negedge clk) begin
        pclk0 <= sclk0;
        pcs0  <= cs0;
        if (!cs0) n_cslow0 <= n_cslow0 + 1;
        if (done0) begin n_done0 <= n_done0 + 1; t_done0 <= $time; end
        if (rvalid0) begin n_rv0 <= n_rv0 + 1; t_rv0 <= $time; end
        if (ready0 && busy0) n_rdybusy0 <= n_rdybusy0 + 1;
        if (pcs0 && !cs0) begin
            n_csfall0 <= n_csfall0 + 1; t_csfall0 <= $time;
            n_frise0 <= 0; miso_sr0 <= miso_word0;
        end
        if (!pcs0 && cs0) t_csrise0 <= $time;
        if (sclk0 && !pclk0) begin
            n_rise0 <= n_rise0 + 1; n_frise0 <= n_frise0 + 1;
            mosi_log0 <= {mosi_log0[62:0], mosi0};
            if (n_frise0 > 0 && ($time - t_rise0) != 8 * CYC) n_bper0 <= n_bper0 + 1;
            t_rise0 <= $time;
        end
        if (sclk0) hi_len0 <= hi_len0 + 1;
        else if (pclk0) begin
            if (hi_len0 != 4) n_bduty0 <= n_bduty0 + 1;
            hi_len0 <= 0;
            if (n_frise0 >= miso_bits0) begin miso0 <= miso_sr0[15]; miso_sr0 <= {miso_sr0[14:0], 1'b0}; end
        end
    end

    // Monitor for dut1 (P_CLKDIV=1)
    logic        pclk1 = 1'b0, pcs1 = 1'b1;
    int          n_rise1 = 0, n_frise1 = 0, n_cslow1 = 0, n_done1 = 0, n_rv1 = 0;
    int          n_bper1 = 0, n_bduty1 = 0, hi_len1 = 0;
    time         t_rise1 = 0;
    logic [15:0] miso_sr1 = 16'h0;

    always @(negedge clk) begin
        pclk1 <= sclk1;
        pcs1  <= cs1;
        if (!cs1) n_cslow1 <= n_cslow1 + 1;
        if (done1) n_done1 <= n_done1 + 1;
        if (rvalid1) n_rv1 <= n_rv1 + 1;
        if (pcs1 && !cs1) begin n_frise1 <= 0; miso_sr1 <= miso_word1; end
        if (sclk1 && !pclk1) begin
            n_rise1 <= n_rise1 + 1; n_frise1 <= n_frise1 + 1;
            if (n_frise1 > 0 && ($time - t_rise1) != 2 * CYC) n_bper1 <= n_bper1 + 1;
            t_rise1 <= $time;
        end
        if (sclk1) hi_len1 <= hi_len1 + 1;
        else if (pclk1) begin
            if (hi_len1 != 1) n_bduty1 <= n_bduty1 + 1;
            hi_len1 <= 0;
            if (n_frise1 >= miso_bits1) begin miso1 <= miso_sr1[15]; miso_sr1 <= {miso_sr1[14:0], 1'b0}; end
        end
    end

    task automatic issue(input int which, input logic [7:0] op, input logic [1:0] na,
                         input logic [23:0] ad, input logic [1:0] nw, input logic [15:0] wd,
                         input logic [1:0] nr, output time acc_t);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_naddr = na; cmd_addr = ad; cmd_nwr = nw; cmd_wdata = wd; cmd_nrd = nr;
        if (which == 0) cmd_valid0 = 1'b1; else cmd_valid1 = 1'b1;
        while (((which == 0) ? ready0 : ready1) == 1'b0 && n < 200) begin @(negedge clk); n++; end
        acc_t = $time;
        tests++;
        if (n >= 200) begin failed++; $display("FAIL accept_timeout dut%0d: CMD_READY low for %0d cycles, required high", which, n); end
        @(negedge clk);
        cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int d0);
        int n = 0;
        while (((which == 0) ? (n_done0 <= d0 || busy0) : (n_done1 <= d0 || busy1)) && n < 3000) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= 3000) begin failed++; $display("FAIL frame_timeout dut%0d: frame not finished in %0d cycles", which, n); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (cs0 !== 1'b1) begin failed++; $display("FAIL rst_cs: got %b expected 1", cs0); end
        tests++; if (sclk0 !== 1'b0) begin failed++; $display("FAIL rst_sclk: got %b expected 0", sclk0); end
        tests++; if (mosi0 !== 1'b0) begin failed++; $display("FAIL rst_mosi: got %b expected 0", mosi0); end
        tests++; if (ready0 !== 1'b0) begin failed++; $display("FAIL rst_ready: got %b expected 0", ready0); end
        tests++; if (rdata0 !== 16'h0) begin failed++; $display("FAIL rst_rdata: got %h expected 0000", rdata0); end
        tests++; if ({rvalid0, done0, busy0} !== 3'b000) begin failed++; $display("FAIL rst_pulses: got %b expected 000", {rvalid0, done0, busy0}); end
        tests++; if (dbg0 !== 3'd0) begin failed++; $display("FAIL rst_state: got %0d expected 0", dbg0); end
        rst = 1'b0;
        #1;
        tests++; if (ready0 !== 1'b0) begin failed++; $display("FAIL rst_ready_early: got %b expected 0", ready0); end
        @(negedge clk);
        tests++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin failed++; $display("FAIL rst_ready_rise: got %b%b expected 11", ready0, ready1); end
    endtask

    task automatic test_write_addr();
        time acc;
        int r0 = n_rise0, c0 = n_cslow0, d0 = n_done0;
        miso_bits0 = 64;
        issue(0, 8'h10, 2'd3, 24'h001234, 2'd0, 16'h0, 2'd0, acc);
        wait_idle(0, d0);
        tests++; if (mosi_log0[31:0] !== 32'h10001234) begin failed++; $display("FAIL addr_mosi: got %h expected 10001234", mosi_log0[31:0]); end
        tests++; if (n_rise0 - r0 != 32) begin failed++; $display("FAIL addr_rises: got %0d expected 32", n_rise0 - r0); end
        tests++; if (n_cslow0 - c0 != 264) begin failed++; $display("FAIL addr_cs_low: got %0d expected 264", n_cslow0 - c0); end
        tests++; if (n_done0 - d0 != 1) begin failed++; $display("FAIL addr_done_cnt: got %0d expected 1", n_done0 - d0); end
        tests++; if (t_done0 - acc != 265 * CYC) begin failed++; $display("FAIL addr_latency: got %0d expected %0d", t_done0 - acc, 265 * CYC); end
    endtask

    task automatic test_read();
        time acc;
        int r0 = n_rise0, v0 = n_rv0, d0 = n_done0;
        miso_word0 = 16'hA500; miso_bits0 = 16;
        issue(0, 8'h0F, 2'd1, 24'h0000C0, 2'd0, 16'h0, 2'd1, acc);
        wait_idle(0, d0);
        tests++; if (rdata0 !== 16'h00A5) begin failed++; $display("FAIL read_data: got %h expected 00a5", rdata0); end
        tests++; if (n_rv0 - v0 != 1) begin failed++; $display("FAIL read_valid_cnt: got %0d expected 1", n_rv0 - v0); end
        tests++; if (t_rv0 != t_done0) begin failed++; $display("FAIL read_valid_align: got %0d expected %0d", t_rv0, t_done0); end
        tests++; if (n_rise0 - r0 != 24) begin failed++; $display("FAIL read_rises: got %0d expected 24", n_rise0 - r0); end
        tests++; if (mosi_log0[23:0] !== 24'h0FC000) begin failed++; $display("FAIL read_mosi: got %h expected 0fc000", mosi_log0[23:0]); end
    endtask

    task automatic test_write_data();
        time acc;
        int r0 = n_rise0, v0 = n_rv0, d0 = n_done0, p0 = n_bper0, q0 = n_bduty0;
        miso_bits0 = 64;
        issue(0, 8'h1F, 2'd1, 24'h0000A0, 2'd1, 16'h007C, 2'd0, acc);
        wait_idle(0, d0);
        tests++; if (mosi_log0[23:0] !== 24'h1FA07C) begin failed++; $display("FAIL wr_mosi: got %h expected 1fa07c", mosi_log0[23:0]); end
        tests++; if (n_rise0 - r0 != 24) begin failed++; $display("FAIL wr_rises: got %0d expected 24", n_rise0 - r0); end
        tests++; if (n_bper0 - p0 != 0) begin failed++; $display("FAIL wr_period: got %0d bad periods expected 0", n_bper0 - p0); end
        tests++; if (n_bduty0 - q0 != 0) begin failed++; $display("FAIL wr_duty: got %0d bad high halves expected 0", n_bduty0 - q0); end
        tests++; if (n_rv0 - v0 != 0) begin failed++; $display("FAIL wr_no_rvalid: got %0d expected 0", n_rv0 - v0); end
        tests++; if (rdata0 !== 16'h00A5) begin failed++; $display("FAIL wr_rdata_hold: got %h expected 00a5", rdata0); end
    endtask

    task automatic test_saturate();
        time acc;
        int r0 = n_rise0, d0 = n_done0;
        miso_word0 = 16'hC3D4; miso_bits0 = 24;
        issue(0, 8'h02, 2'd0, 24'h0, 2'd3, 16'h1357, 2'd3, acc);
        wait_idle(0, d0);
        tests++; if (n_rise0 - r0 != 40) begin failed++; $display("FAIL sat_rises: got %0d expected 40", n_rise0 - r0); end
        tests++; if (mosi_log0[39:0] !== 40'h0213570000) begin failed++; $display("FAIL sat_mosi: got %h expected 0213570000", mosi_log0[39:0]); end
        tests++; if (rdata0 !== 16'hC3D4) begin failed++; $display("FAIL sat_rdata: got %h expected c3d4", rdata0); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int d0 = n_done0, f0 = n_csfall0, b0 = n_rdybusy0;
        miso_bits0 = 64;
        @(negedge clk);
        cmd_op = 8'h06; cmd_naddr = 2'd0; cmd_nwr = 2'd0; cmd_nrd = 2'd0;
        cmd_valid0 = 1'b1;
        while (n_csfall0 < f0 + 2 && n < 1000) begin @(negedge clk); n++; end
        tests++; if (n >= 1000) begin failed++; $display("FAIL b2b_timeout: got %0d CS falls expected 2", n_csfall0 - f0); end
        tests++; if (ready0 !== 1'b0) begin failed++; $display("FAIL b2b_ready_setup: got %b expected 0", ready0); end
        cmd_valid0 = 1'b0;
        tests++; if (t_csfall0 - t_csrise0 != 9 * CYC) begin failed++; $display("FAIL b2b_gap: got %0d expected %0d", t_csfall0 - t_csrise0, 9 * CYC); end
        wait_idle(0, d0 + 1);
        tests++; if (n_done0 - d0 != 2) begin failed++; $display("FAIL b2b_done_cnt: got %0d expected 2", n_done0 - d0); end
        tests++; if (n_rdybusy0 - b0 != 0) begin failed++; $display("FAIL b2b_ready_busy: got %0d cycles expected 0", n_rdybusy0 - b0); end
    endtask

    task automatic test_reset_mid_frame();
        time acc;
        int n = 0;
        int r0 = n_rise0, d0 = n_done0, c0;
        miso_bits0 = 64;
        issue(0, 8'h10, 2'd3, 24'h001234, 2'd0, 16'h0, 2'd0, acc);
        while (n_rise0 - r0 < 13 && n < 1000) begin @(negedge clk); n++; end
        #2 rst = 1'b1;
        #1;
        tests++; if (cs0 !== 1'b1 || sclk0 !== 1'b0) begin failed++; $display("FAIL mid_rst_bus: got cs=%b clk=%b expected cs=1 clk=0", cs0, sclk0); end
        tests++; if (busy0 !== 1'b0 || mosi0 !== 1'b0) begin failed++; $display("FAIL mid_rst_busy: got busy=%b mosi=%b expected 0 0", busy0, mosi0); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (n_done0 != d0) begin failed++; $display("FAIL mid_rst_no_done: got %0d DONE expected 0", n_done0 - d0); end
        tests++; if (rdata0 !== 16'h0) begin failed++; $display("FAIL mid_rst_rdata: got %h expected 0000", rdata0); end
        r0 = n_rise0; d0 = n_done0; c0 = n_cslow0;
        miso_word0 = 16'h5AC3; miso_bits0 = 8;
        issue(0, 8'h9F, 2'd0, 24'h0, 2'd0, 16'h0, 2'd2, acc);
        wait_idle(0, d0);
        tests++; if (rdata0 !== 16'h5AC3) begin failed++; $display("FAIL post_rst_rdata: got %h expected 5ac3", rdata0); end
        tests++; if (n_rise0 - r0 != 24) begin failed++; $display("FAIL post_rst_rises: got %0d expected 24", n_rise0 - r0); end
        tests++; if (n_cslow0 - c0 != 200) begin failed++; $display("FAIL post_rst_cs_low: got %0d expected 200", n_cslow0 - c0); end
        tests++; if (mosi_log0[23:0] !== 24'h9F0000) begin failed++; $display("FAIL post_rst_mosi: got %h expected 9f0000", mosi_log0[23:0]); end
    endtask

    task automatic test_clkdiv1();
        time acc;
        int r0 = n_rise1, d0 = n_done1, v0 = n_rv1, c0 = n_cslow1, p0 = n_bper1, q0 = n_bduty1;
        miso_word1 = 16'hBEEF; miso_bits1 = 8;
        issue(1, 8'h05, 2'd0, 24'h0, 2'd0, 16'h0, 2'd2, acc);
        wait_idle(1, d0);
        tests++; if (rdata1 !== 16'hBEEF) begin failed++; $display("FAIL div1_rdata: got %h expected beef", rdata1); end
        tests++; if (n_rise1 - r0 != 24) begin failed++; $display("FAIL div1_rises: got %0d expected 24", n_rise1 - r0); end
        tests++; if (n_bper1 - p0 != 0 || n_bduty1 - q0 != 0) begin failed++; $display("FAIL div1_toggle: got %0d/%0d bad periods/halves expected 0/0", n_bper1 - p0, n_bduty1 - q0); end
        tests++; if (n_rv1 - v0 != 1) begin failed++; $display("FAIL div1_rvalid: got %0d expected 1", n_rv1 - v0); end
        tests++; if (n_cslow1 - c0 != 56) begin failed++; $display("FAIL div1_cs_low: got %0d expected 56", n_cslow1 - c0); end
    endtask

    initial begin
        #(CYC * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_addr();
        test_read();
        test_write_data();
        test_saturate();
        test_back_to_back();
        test_reset_mid_frame();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
